// File: rtl/cache_pkg.sv
// Shared sizes and types for the cache and its refill controller.
package cache_pkg;

    localparam int NumSets       = 4;
    localparam int Associativity = 2;
    localparam int SetWidth      = (NumSets > 1) ? $clog2(NumSets) : 1;
    localparam int TagWidth      = 8;
    localparam int WayWidth      = (Associativity > 1) ? $clog2(Associativity) : 1;
    localparam int DataWidth     = 16;
    localparam int AddrWidth     = TagWidth + SetWidth;

    typedef struct packed {
        logic                valid;
        logic [TagWidth-1:0] tag;
    } block_info_t;

    typedef logic [DataWidth-1:0] block_data_t;

    // One full info line: every way of a set, way 0 in the low bits.
    typedef block_info_t [Associativity-1:0] info_line_t;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        REQ,
        WAIT,
        WRITE
    } refill_state_e;

    // True when some way of the line already holds a valid copy of the tag.
    function automatic logic line_hit(input info_line_t line, input logic [TagWidth-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < Associativity; i++) begin
            if (line[i].valid && (line[i].tag == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Returns the line with one way overwritten by a freshly valid tag.
    function automatic info_line_t line_replace(input info_line_t line,
                                                input logic [WayWidth-1:0] way,
                                                input logic [TagWidth-1:0] tag);
        info_line_t result;
        result = line;
        for (int i = 0; i < Associativity; i++) begin
            if (WayWidth'(i) == way) begin
                result[i].valid = 1'b1;
                result[i].tag   = tag;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cache_refill_if.sv
// Miss, memory and cache-write-port signals of the refill controller.
interface cache_refill_if;
    import cache_pkg::*;

    // miss request from the pipeline
    logic                miss_valid_i;
    logic                miss_ready_o;
    logic [SetWidth-1:0] miss_set_i;
    logic [TagWidth-1:0] miss_tag_i;

    // memory read request / response
    logic                 mem_req_valid_o;
    logic                 mem_req_ready_i;
    logic [AddrWidth-1:0] mem_req_addr_o;
    logic                 mem_rsp_valid_i;
    logic                 mem_rsp_ready_o;
    block_data_t          mem_rsp_data_i;

    // cache write port and status
    logic                write_en_o;
    logic [SetWidth-1:0] write_set_o;
    info_line_t          write_info_o;
    logic [WayWidth-1:0] write_data_way_o;
    block_data_t         write_data_o;
    logic                refill_done_o;
    logic                init_done_o;

    // Controller side.
    modport master (
        input  miss_valid_i, miss_set_i, miss_tag_i,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        output miss_ready_o, mem_req_valid_o, mem_req_addr_o, mem_rsp_ready_o,
        output write_en_o, write_set_o, write_info_o, write_data_way_o, write_data_o,
        output refill_done_o, init_done_o
    );

    // Pipeline / memory / cache side.
    modport slave (
        output miss_valid_i, miss_set_i, miss_tag_i,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        input  miss_ready_o, mem_req_valid_o, mem_req_addr_o, mem_rsp_ready_o,
        input  write_en_o, write_set_o, write_info_o, write_data_way_o, write_data_o,
        input  refill_done_o, init_done_o
    );

endinterface

// File: rtl/cache_refill_victim_select.sv
// Victim way choice: lowest invalid way, else the set's round-robin pointer.
module victim_select
    import cache_pkg::*;
(
    input  info_line_t          line,
    input  logic [WayWidth-1:0] rr_ptr,
    output logic [WayWidth-1:0] way,
    output logic                use_rr
);

    logic [Associativity-1:0] invalid_vec;

    for (genvar gi = 0; gi < Associativity; gi++) begin : g_invalid
        assign invalid_vec[gi] = ~line[gi].valid;
    end

    // Scan from the top so the lowest invalid way wins.
    always_comb begin
        way    = rr_ptr;
        use_rr = 1'b1;
        for (int i = Associativity - 1; i >= 0; i--) begin
            if (invalid_vec[i]) begin
                way    = WayWidth'(i);
                use_rr = 1'b0;
            end
        end
        if (Associativity == 1) begin
            way    = '0;
            use_rr = 1'b0;
        end
    end

endmodule

// File: rtl/cache_refill.sv
// Refill controller: invalidation sweep after reset, then one miss at a time
// fetched from memory and written into the cache through its write port.
module cache_refill
    import cache_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    cache_refill_if.master bus
);

    localparam logic [SetWidth-1:0] LastSet = SetWidth'(NumSets - 1);

    refill_state_e       state_reg, state_next;
    logic [SetWidth-1:0] k_reg, k_next;
    logic [SetWidth-1:0] set_reg;
    logic [TagWidth-1:0] tag_reg;
    logic [WayWidth-1:0] way_reg;
    info_line_t          line_reg;
    logic                dup_reg;
    block_data_t         data_reg;

    // The cache only accepts whole info lines, so this copy is the reference
    // for what each set currently holds.
    info_line_t          shadow_mem [NumSets];
    logic [WayWidth-1:0] rr_mem     [NumSets];

    info_line_t          cur_line;
    logic [WayWidth-1:0] cur_rr;
    logic [WayWidth-1:0] victim_way;
    logic                victim_use_rr;
    logic                hit;
    logic                miss_fire;
    logic                rsp_fire;

    assign cur_line  = shadow_mem[bus.miss_set_i];
    assign cur_rr    = rr_mem[bus.miss_set_i];
    assign hit       = line_hit(cur_line, bus.miss_tag_i);
    assign miss_fire = (state_reg == IDLE) && bus.miss_valid_i;
    assign rsp_fire  = (state_reg == WAIT) && bus.mem_rsp_valid_i;

    victim_select u_victim (
        .line   (cur_line),
        .rr_ptr (cur_rr),
        .way    (victim_way),
        .use_rr (victim_use_rr)
    );

    // State, sweep counter and the per-miss context latched at acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= INIT;
            k_reg     <= '0;
            set_reg   <= '0;
            tag_reg   <= '0;
            way_reg   <= '0;
            line_reg  <= '0;
            dup_reg   <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            if (miss_fire) begin
                set_reg  <= bus.miss_set_i;
                tag_reg  <= bus.miss_tag_i;
                way_reg  <= victim_way;
                line_reg <= line_replace(cur_line, victim_way, bus.miss_tag_i);
                dup_reg  <= hit;
            end
            if (rsp_fire) begin
                data_reg <= bus.mem_rsp_data_i;
            end
        end
    end

    // Shadow info and round-robin pointers; INIT rewrites every entry before use.
    always_ff @(posedge clk_i) begin
        if (state_reg == INIT) begin
            shadow_mem[k_reg] <= '0;
            rr_mem[k_reg]     <= '0;
        end else begin
            if (miss_fire && !hit && victim_use_rr) begin
                rr_mem[bus.miss_set_i] <= (cur_rr == WayWidth'(Associativity - 1)) ?
                                          '0 : cur_rr + 1'b1;
            end
            if ((state_reg == WRITE) && !dup_reg) begin
                shadow_mem[set_reg] <= line_reg;
            end
        end
    end

    // Next state plus outputs decoded from the registered state.
    always_comb begin
        state_next           = state_reg;
        k_next               = k_reg;
        bus.miss_ready_o     = 1'b0;
        bus.mem_req_valid_o  = 1'b0;
        bus.mem_req_addr_o   = '0;
        bus.mem_rsp_ready_o  = 1'b0;
        bus.write_en_o       = 1'b0;
        bus.write_set_o      = '0;
        bus.write_info_o     = '0;
        bus.write_data_way_o = '0;
        bus.write_data_o     = '0;
        bus.refill_done_o    = 1'b0;
        bus.init_done_o      = 1'b1;

        case (state_reg)
            INIT: begin
                bus.init_done_o = 1'b0;
                bus.write_en_o  = 1'b1;
                bus.write_set_o = k_reg;
                if (k_reg == LastSet) begin
                    k_next     = '0;
                    state_next = IDLE;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            IDLE: begin
                bus.miss_ready_o = 1'b1;
                if (bus.miss_valid_i) begin
                    state_next = hit ? WRITE : REQ;
                end
            end
            REQ: begin
                bus.mem_req_valid_o = 1'b1;
                bus.mem_req_addr_o  = {tag_reg, set_reg};
                if (bus.mem_req_ready_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                bus.mem_rsp_ready_o = 1'b1;
                if (bus.mem_rsp_valid_i) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                bus.refill_done_o = 1'b1;
                if (!dup_reg) begin
                    bus.write_en_o       = 1'b1;
                    bus.write_set_o      = set_reg;
                    bus.write_info_o     = line_reg;
                    bus.write_data_way_o = way_reg;
                    bus.write_data_o     = data_reg;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = INIT;
                k_next     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill with a queue-based scoreboard monitor.
module tb_cache_refill;
    import cache_pkg::*;

    typedef struct {
        logic [SetWidth-1:0] set;
        info_line_t          info;
        logic [WayWidth-1:0] way;
        block_data_t         data;
    } wr_exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;

    wr_exp_t              wr_q[$];
    logic                 done_q[$];
    logic [AddrWidth-1:0] req_q[$];
    wr_exp_t              mon_wr;
    logic                 mon_done;
    logic [AddrWidth-1:0] mon_addr;

    cache_refill_if bus();

    cache_refill u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic info_line_t mk_line(input logic v1, input logic [TagWidth-1:0] t1,
                                           input logic v0, input logic [TagWidth-1:0] t0);
        info_line_t l;
        l[1].valid = v1;
        l[1].tag   = t1;
        l[0].valid = v0;
        l[0].tag   = t0;
        return l;
    endfunction

    // Scoreboard monitor: pops an expectation whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.write_en_o) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_write: set=%0d info=%h way=%0d data=%h",
                             bus.write_set_o, bus.write_info_o, bus.write_data_way_o, bus.write_data_o);
                end else begin
                    mon_wr = wr_q.pop_front();
                    chk("write_set", bus.write_set_o, mon_wr.set);
                    chk("write_info", bus.write_info_o, mon_wr.info);
                    chk("write_way", bus.write_data_way_o, mon_wr.way);
                    chk("write_data", bus.write_data_o, mon_wr.data);
                    $display("write set=%0d info=%h way=%0d data=%h",
                             bus.write_set_o, bus.write_info_o, bus.write_data_way_o, bus.write_data_o);
                end
            end
            if (bus.refill_done_o) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_done: write_en=%0b", bus.write_en_o);
                end else begin
                    mon_done = done_q.pop_front();
                    chk("done_write_en", bus.write_en_o, mon_done);
                    $display("refill_done write_en=%0b", bus.write_en_o);
                end
            end
            if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
                if (req_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_req: addr=%h", bus.mem_req_addr_o);
                end else begin
                    mon_addr = req_q.pop_front();
                    chk("req_addr", bus.mem_req_addr_o, mon_addr);
                    $display("mem_req addr=%h", bus.mem_req_addr_o);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_write_en"}, bus.write_en_o, 1);
        chk({tag, "_write_set"}, bus.write_set_o, 0);
        chk({tag, "_write_info"}, bus.write_info_o, 0);
        chk({tag, "_miss_ready"}, bus.miss_ready_o, 0);
        chk({tag, "_req_valid"}, bus.mem_req_valid_o, 0);
        chk({tag, "_rsp_ready"}, bus.mem_rsp_ready_o, 0);
        chk({tag, "_done"}, bus.refill_done_o, 0);
        chk({tag, "_init_done"}, bus.init_done_o, 0);
    endtask

    // Releases reset and checks the sweep length; expects 4 invalidating writes.
    task automatic release_and_sweep(input string tag);
        for (int k = 0; k < NumSets; k++) begin
            wr_q.push_back('{set: SetWidth'(k), info: '0, way: '0, data: '0});
        end
        tick();
        rst_n = 1'b1;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = '0;
        tick();
        tick();
        tick();
        chk({tag, "_init_done_c4"}, bus.init_done_o, 0);
        tick();
        chk({tag, "_init_done_c5"}, bus.init_done_o, 1);
        chk({tag, "_sweep_writes"}, wr_q.size(), 0);
    endtask

    task automatic issue_miss(input logic [SetWidth-1:0] s, input logic [TagWidth-1:0] t,
                              input block_data_t d, input int req_hold, input int rsp_delay,
                              input logic [WayWidth-1:0] w, input info_line_t line, input bit dup);
        int guard;
        if (dup) begin
            done_q.push_back(1'b0);
        end else begin
            req_q.push_back({t, s});
            wr_q.push_back('{set: s, info: line, way: w, data: d});
            done_q.push_back(1'b1);
        end
        guard = 0;
        while (!bus.miss_ready_o && guard < 50) begin
            tick();
            guard++;
        end
        chk("miss_ready_idle", bus.miss_ready_o, 1);
        bus.miss_valid_i = 1'b1;
        bus.miss_set_i   = s;
        bus.miss_tag_i   = t;
        tick();
        bus.miss_valid_i = 1'b0;
        chk("miss_ready_busy", bus.miss_ready_o, 0);
        if (dup) begin
            chk("dup_done_cycle1", bus.refill_done_o, 1);
            chk("dup_no_req", bus.mem_req_valid_o, 0);
            chk("dup_no_write", bus.write_en_o, 0);
            tick();
        end else begin
            for (int i = 0; i < req_hold; i++) begin
                chk("req_valid_hold", bus.mem_req_valid_o, 1);
                chk("req_addr_hold", bus.mem_req_addr_o, {t, s});
                chk("rsp_ready_in_req", bus.mem_rsp_ready_o, 0);
                chk("miss_ready_in_req", bus.miss_ready_o, 0);
                tick();
            end
            chk("req_valid", bus.mem_req_valid_o, 1);
            bus.mem_req_ready_i = 1'b1;
            tick();
            bus.mem_req_ready_i = 1'b0;
            chk("req_dropped", bus.mem_req_valid_o, 0);
            for (int i = 0; i < rsp_delay; i++) begin
                chk("rsp_ready_wait", bus.mem_rsp_ready_o, 1);
                chk("miss_ready_in_wait", bus.miss_ready_o, 0);
                tick();
            end
            chk("rsp_ready", bus.mem_rsp_ready_o, 1);
            bus.mem_rsp_valid_i = 1'b1;
            bus.mem_rsp_data_i  = d;
            tick();
            bus.mem_rsp_valid_i = 1'b0;
            bus.mem_rsp_data_i  = '0;
            chk("refill_done", bus.refill_done_o, 1);
            chk("miss_ready_in_write", bus.miss_ready_o, 0);
            tick();
        end
        chk("miss_ready_after", bus.miss_ready_o, 1);
        chk("done_single_pulse", bus.refill_done_o, 0);
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.miss_valid_i    = 1'b0;
        bus.miss_set_i      = '0;
        bus.miss_tag_i      = '0;
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = '0;

        tick();
        check_reset_outputs("reset");
        release_and_sweep("init");

        // single miss into an empty set
        issue_miss(2'd2, 8'h15, 16'hDEAD, 0, 0, 1'b0, mk_line(0, 8'h00, 1, 8'h15), 0);

        // fill set 1 then evict round-robin
        issue_miss(2'd1, 8'h0A, 16'h1111, 0, 0, 1'b0, mk_line(0, 8'h00, 1, 8'h0A), 0);
        issue_miss(2'd1, 8'h0B, 16'h2222, 0, 0, 1'b1, mk_line(1, 8'h0B, 1, 8'h0A), 0);
        issue_miss(2'd1, 8'h0C, 16'h3333, 0, 0, 1'b0, mk_line(1, 8'h0B, 1, 8'h0C), 0);
        issue_miss(2'd1, 8'h0D, 16'h4444, 0, 0, 1'b1, mk_line(1, 8'h0D, 1, 8'h0C), 0);

        // duplicate miss
        issue_miss(2'd3, 8'h07, 16'h0777, 0, 0, 1'b0, mk_line(0, 8'h00, 1, 8'h07), 0);
        issue_miss(2'd3, 8'h07, 16'h0000, 0, 0, 1'b0, '0, 1);

        // backpressure on request and response
        issue_miss(2'd0, 8'h33, 16'hBEEF, 5, 3, 1'b0, mk_line(0, 8'h00, 1, 8'h33), 0);

        // reset while waiting for the response: the block must never be written
        req_q.push_back({8'h44, 2'd2});
        bus.miss_valid_i = 1'b1;
        bus.miss_set_i   = 2'd2;
        bus.miss_tag_i   = 8'h44;
        tick();
        bus.miss_valid_i    = 1'b0;
        bus.mem_req_ready_i = 1'b1;
        tick();
        bus.mem_req_ready_i = 1'b0;
        chk("abort_in_wait", bus.mem_rsp_ready_o, 1);
        rst_n               = 1'b0;
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = 16'hBAD0;
        check_reset_outputs("abort");
        release_and_sweep("reinit");

        // set 2 was swept, so tag 0x15 is a fresh miss again
        issue_miss(2'd2, 8'h15, 16'hCAFE, 0, 0, 1'b0, mk_line(0, 8'h00, 1, 8'h15), 0);

        tick();
        tick();
        chk("wr_q_empty", wr_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        chk("req_q_empty", req_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_refill.md
# cache_refill

Miss-handling refill controller that owns the cache's write port. After reset it sweeps every set to invalid. It then accepts one miss at a time, fetches the block from memory over a valid/ready request and response interface, and picks a victim way. It writes tag, valid and data into the cache through the cache's write port. It sits beside the read-hit-only `cache`: the pipeline raises a miss when `read_hit_o` is low and replays the read after `refill_done_o`.

## Interface
- No module parameters. All sizes come from `cache_pkg`: `NumSets`, `Associativity`, `SetWidth`, `TagWidth`, `WayWidth`, `DataWidth`, `block_info_t` (`valid`, `tag`), `block_data_t`.
- `clk_i`  in  1  clock, the only clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `miss_valid_i`  in  1  miss request.
- `miss_ready_o`  out  1  miss accepted when both `miss_valid_i` and `miss_ready_o` are high.
- `miss_set_i`  in  SetWidth  set of the missing address.
- `miss_tag_i`  in  TagWidth  tag of the missing address.
- `mem_req_valid_o`  out  1  memory read request.
- `mem_req_ready_i`  in  1  memory accepts the request.
- `mem_req_addr_o`  out  TagWidth+SetWidth  block address, `{tag, set}`.
- `mem_rsp_valid_i`  in  1  memory response valid.
- `mem_rsp_ready_o`  out  1  controller accepts the response.
- `mem_rsp_data_i`  in  DataWidth  block data.
- `write_en_o`  out  1  cache write strobe.
- `write_set_o`  out  SetWidth  cache write set.
- `write_info_o`  out  Associativity×block_info_t  full info line for the set being written.
- `write_data_way_o`  out  WayWidth  way receiving the data.
- `write_data_o`  out  block_data_t  block data.
- `refill_done_o`  out  1  one-cycle pulse when a miss completes.
- `init_done_o`  out  1  high once the invalidation sweep has finished.

## Operation
- Shadow state:
  - The controller keeps a shadow info array (`NumSets` × `Associativity` × `block_info_t`).
  - It keeps one round-robin pointer per set (`WayWidth` bits each).
  - The cache writes whole info lines, so the shadow array is the only source of the current line.
- States: INIT, IDLE, REQ, WAIT, WRITE.
- INIT:
  - Counter `k` runs from 0 to NumSets-1.
  - Each cycle drives `write_en_o=1`, `write_set_o=k`, all ways invalid with tag 0, `write_data_way_o=0`, `write_data_o=0`.
  - The shadow array and the pointers are cleared.
  - After `k=NumSets-1` the state moves to IDLE.
- IDLE:
  - `miss_ready_o=1`.
  - On acceptance, latch set and tag.
  - If the shadow line already holds a valid matching tag (a duplicate miss), go straight to WRITE with the write suppressed.
  - Otherwise go to REQ.
- Victim selection, done at acceptance:
  - The lowest-index invalid way, if one exists.
  - Otherwise `rr[set]`, and `rr[set]` then increments modulo `Associativity`.
  - When `Associativity==1` the victim is always way 0.
- REQ: `mem_req_valid_o=1` and the address stay stable until `mem_req_ready_i`, then the state moves to WAIT.
- WAIT: `mem_rsp_ready_o=1`. On `mem_rsp_valid_i`, capture the data and move to WRITE.
- WRITE:
  - For one cycle: `write_en_o=1`, set, the shadow line with the victim way replaced by `{valid=1, tag}`, victim way, and the captured data.
  - The shadow array is updated on the same edge.
  - `refill_done_o=1`, then the state returns to IDLE.
  - For a duplicate miss: `write_en_o=0`, `refill_done_o=1`.

## Timing
- Reset values: state INIT, `k=0`. While `rst_ni` is low, outputs are the INIT outputs for set 0: `write_en_o=1`, all-invalid info. This write is idempotent. Every other output is 0.
- Outputs are decoded from state registers only, with no combinational input-to-output paths, except that the handshake acceptance terms use the inputs.
- INIT lasts exactly NumSets cycles after reset release. `init_done_o` rises on the first IDLE cycle.
- Minimum miss latency, with memory ready and the response in the same cycle:
  - accept in cycle 0,
  - REQ in cycle 1,
  - WAIT in cycle 2,
  - WRITE and `refill_done_o` in cycle 3.
- Duplicate miss: `refill_done_o` appears in cycle 1 and memory sees no request.
- `miss_ready_o` stays 0 from acceptance through WRITE. The earliest next acceptance is the cycle after WRITE.
- A response arriving outside WAIT is not accepted.
- Reset asserted mid-refill:
  - All state is aborted and INIT restarts.
  - The memory side must be reset together with the controller.
  - An unaccepted `mem_rsp_valid_i` after reset is never consumed.

## Structure
- In `cache_pkg`: the new `refill_state_e` enum; address width `AddrWidth = TagWidth+SetWidth`. The existing `block_info_t`, `block_data_t` and widths are reused.
- One natural sub-module, `victim_select`: combinational, with inputs the info line and the pointer and outputs the way and whether the pointer is used.

## Test plan
- Init sweep: release reset with NumSets=4 → exactly 4 writes to sets 0,1,2,3 with all valid bits 0 → `init_done_o=1` in cycle 5.
- Single miss: set 2, tag 0x15; memory ready with 1-cycle response data 0xDEAD → write to set 2, way 0, `{valid=1, tag=0x15}`, data 0xDEAD; `refill_done_o` pulses once.
- Fill then evict, Associativity=2, set 1:
  - misses on tags A and B fill ways 0 and 1;
  - tag C evicts way 0;
  - tag D evicts way 1;
  - other ways' info is preserved in every `write_info_o`.
- Duplicate miss: refill tag 0x7 into set 3, then miss again on set 3 tag 0x7 → no `mem_req_valid_o`, no write, `refill_done_o` one cycle after acceptance.
- Backpressure: hold `mem_req_ready_i=0` for 5 cycles and delay the response 3 cycles → request and address stable throughout; exactly one write; `miss_ready_o=0` until after WRITE.
- Reset in WAIT: assert `rst_ni=0` mid-refill → outputs take reset values; INIT sweep restarts; no write of the aborted block.
